// File: rtl/line_delay_1024x18.sv
// ---------------------------------------------------------------------------
// line_delay_1024x18
//
// Single-line delay controller placed in front of an external 1024xDW simple
// dual-port line RAM with unregistered output and 1-cycle read latency.
// Produces the RAM write/read addresses from an incoming pixel stream.
// Recombines the RAM output with the delayed current pixel into a column
// aligned pair: the current-row pixel and the pixel directly above it.
//
// Ports
//   clk           single clock (this block and both RAM ports)
//   rst_n         synchronous active-low reset
//   in_valid      input pixel qualifier (gaps allowed)
//   in_data       input pixel
//   in_sof        first pixel of frame (with in_valid)
//   in_eol        last pixel of line (with in_valid)
//   ram_wr_en     RAM write enable
//   ram_wr_addr   RAM write address
//   ram_wr_data   RAM write data
//   ram_rd_addr   RAM read address (combinational from current inputs)
//   ram_rd_data   RAM read data (valid one cycle after ram_rd_addr)
//   out_valid     output pair qualifier, 2 cycles after in_valid
//   out_cur       current-row pixel
//   out_up        same column, previous row (0 when out_up_valid=0)
//   out_up_valid  a previous row of this frame exists
//   out_sof       sof flag aligned to out_valid
//   out_eol       eol flag aligned to out_valid
//   line_err      sticky line-length error, cleared only by reset
// ---------------------------------------------------------------------------
module line_delay_1024x18 #(
  parameter int IMG_WIDTH = 640,
  parameter int DW        = 18,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_sof,
  input  logic          in_eol,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_wr_data,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rd_data,
  output logic          out_valid,
  output logic [DW-1:0] out_cur,
  output logic [DW-1:0] out_up,
  output logic          out_up_valid,
  output logic          out_sof,
  output logic          out_eol,
  output logic          line_err
);

  localparam logic [AW-1:0] LAST_COL = AW'(IMG_WIDTH - 1);

  // Input-side state
  logic [AW-1:0] r_col;
  logic          r_have_prev;
  logic          r_line_err;

  // Stage d1: one valid-stage delay feeding the RAM write port
  logic          r_d1_valid;
  logic [AW-1:0] r_d1_col;
  logic [DW-1:0] r_d1_data;
  logic          r_d1_sof;
  logic          r_d1_eol;
  logic          r_d1_up_ok;

  // Stage d2: output registers
  logic          r_out_valid;
  logic [DW-1:0] r_out_cur;
  logic [DW-1:0] r_out_up;
  logic          r_out_up_valid;
  logic          r_out_sof;
  logic          r_out_eol;

  logic [AW-1:0] w_ecol;
  logic          w_last_col;
  logic          w_line_end;
  logic          w_len_err;
  logic          w_up_ok;
  logic          w_d1_up_en;

  // A sof always restarts at column 0, whatever the counter says.
  assign w_ecol     = in_sof ? '0 : r_col;
  assign w_last_col = (w_ecol == LAST_COL);
  // A line closes on an explicit eol or on reaching the last column.
  assign w_line_end = in_eol | w_last_col;
  // Exactly one of the two line-end causes means the line length is wrong.
  assign w_len_err  = in_eol ^ w_last_col;
  // A sof pixel never has a row above it, even if one was seen earlier.
  assign w_up_ok    = r_have_prev & ~in_sof;
  assign w_d1_up_en = r_d1_valid & r_d1_up_ok;

  // Reading the current column in the arrival cycle while writing the
  // previous pixel's column one cycle later guarantees read-before-write
  // per column and distinct addresses in any single cycle.
  assign ram_rd_addr = w_ecol;
  assign ram_wr_en   = r_d1_valid & rst_n;
  assign ram_wr_addr = r_d1_col;
  assign ram_wr_data = r_d1_data;

  assign out_valid    = r_out_valid;
  assign out_cur      = r_out_cur;
  assign out_up       = r_out_up;
  assign out_up_valid = r_out_up_valid;
  assign out_sof      = r_out_sof;
  assign out_eol      = r_out_eol;
  assign line_err     = r_line_err;

  // NOTE: every register below is assigned with <= so all stages sample the
  // pre-edge values of each other; blocking here would collapse the pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col          <= '0;
      r_have_prev    <= 1'b0;
      r_line_err     <= 1'b0;
      r_d1_valid     <= 1'b0;
      r_d1_col       <= '0;
      r_d1_data      <= '0;
      r_d1_sof       <= 1'b0;
      r_d1_eol       <= 1'b0;
      r_d1_up_ok     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_cur      <= '0;
      r_out_up       <= '0;
      r_out_up_valid <= 1'b0;
      r_out_sof      <= 1'b0;
      r_out_eol      <= 1'b0;
    end else begin
      // Column / row tracking advances only on valid pixels.
      if (in_valid) begin
        r_col       <= w_line_end ? '0 : w_ecol + AW'(1);
        r_have_prev <= w_line_end | w_up_ok;
        if (w_len_err) begin
          r_line_err <= 1'b1;
        end
      end

      // Stage d1: data fields hold across gaps, only the qualifier drops.
      r_d1_valid <= in_valid;
      if (in_valid) begin
        r_d1_col   <= w_ecol;
        r_d1_data  <= in_data;
        r_d1_sof   <= in_sof;
        r_d1_eol   <= in_eol;
        r_d1_up_ok <= w_up_ok;
      end

      // Stage d2: ram_rd_data now holds the column read during d1's input
      // cycle. Stale RAM contents are masked here rather than cleared.
      r_out_valid    <= r_d1_valid;
      r_out_cur      <= r_d1_data;
      r_out_up_valid <= w_d1_up_en;
      r_out_up       <= w_d1_up_en ? ram_rd_data : '0;
      r_out_sof      <= r_d1_valid & r_d1_sof;
      r_out_eol      <= r_d1_valid & r_d1_eol;
    end
  end

endmodule
